instr_fetch_unit: RTL and testbench

//  Producer side of the opcode path into controlunit: owns the PC, fetches 32-bit instructions

---
 rtl/instr_fetch_unit_pkg.sv | 16 +
 rtl/instr_fetch_unit_next_pc.sv | 34 +++
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 tb/tb_instr_fetch_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared MIPS opcode definitions used by the fetch unit and the control unit.
// Keeps instruction-field decoding in one place so both sides agree on encodings.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC selection for the fetch unit: redirect target, j target, or pc+4.
// The result is always word aligned.
module fetch_next_pc
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] instr_pc,
  input  logic [31:0]       instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jump_pc;
  logic [ADDR_W-1:0] sel_pc;

  // Wraps modulo 2^ADDR_W; the j target keeps the top nibble of the sequential pc.
  assign seq_pc  = instr_pc + ADDR_W'(4);
  assign jump_pc = {seq_pc[ADDR_W-1:28], instr[25:0], 2'b00};

  always_comb begin
    sel_pc = seq_pc;
    if (redirect_valid) begin
      sel_pc = redirect_pc;
    end else if (opcode_of(instr) == OP_J) begin
      sel_pc = jump_pc;
    end
  end

  assign next_pc = sel_pc & ~ADDR_W'(3);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over an imem req/ack handshake and hands
// instructions to decode over valid/ready, resolving j locally and honouring beq redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              squash;

  fetch_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .instr_pc      (instr_pc),
    .instr         (instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .next_pc       (next_pc)
  );

  assign imem_addr = pc;
  assign opcode    = opcode_of(instr);

  // A redirect seen before the ack leaves one stale reply in flight; squash drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC & ~ADDR_W'(3);
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      squash      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (redirect_valid) begin
            pc     <= next_pc;
            squash <= ~imem_ack;
          end else if (imem_ack) begin
            if (squash) begin
              squash <= 1'b0;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            if (opcode == OP_HALT) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a delay-programmable imem responder.
// A second instance exercises a RESET_PC at the top of the address space.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0020;
  localparam logic [31:0] LW   = 32'h8C22_0004;
  localparam logic [31:0] SW   = 32'hAC23_0008;
  localparam logic [31:0] HLT  = 32'hFC00_0000;
  localparam logic [31:0] JMP  = 32'h0800_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  logic        rst2;
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] instr2;
  logic [5:0]  opcode2;
  logic [31:0] instr_pc2;
  logic        valid2;
  logic        halted2;

  logic [31:0] mem [0:255];
  int          ack_delay;
  logic        manual_en;
  logic        man_ack;
  logic [31:0] man_rdata;
  logic        model_ack = 1'b0;
  logic [31:0] model_rdata = '0;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] lat_addr = '0;

  int          cyc = 0;
  int          rel_base = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] req_log [$];
  logic [31:0] xfer_pc [$];
  logic [31:0] xfer_instr [$];
  int          xfer_cyc [$];
  int          addr_changes = 0;
  int          instr_changes = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_valid = 1'b0;
  logic        prev_xfer = 1'b0;
  logic [31:0] prev_instr = '0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(NOP), .instr(instr2), .opcode(opcode2),
    .instr_pc(instr_pc2), .instr_valid(valid2), .instr_ready(1'b1),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halted(halted2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  assign imem_ack   = manual_en ? man_ack   : model_ack;
  assign imem_rdata = manual_en ? man_rdata : model_rdata;

  // imem model: latches the address at request start and acks after ack_delay wait cycles.
  always @(negedge clk) begin
    if (!imem_req) begin
      busy      = 1'b0;
      model_ack = 1'b0;
    end else begin
      if (!busy || model_ack) begin
        busy     = 1'b1;
        cnt      = 0;
        lat_addr = imem_addr;
        req_log.push_back(imem_addr);
      end else begin
        cnt = cnt + 1;
      end
      model_ack   = (cnt >= ack_delay);
      model_rdata = mem[lat_addr[9:2]];
    end
  end

  always @(negedge clk) begin
    if (instr_valid && instr_ready && !redirect_valid) begin
      xfer_pc.push_back(instr_pc);
      xfer_instr.push_back(instr);
      xfer_cyc.push_back(cyc - rel_base);
    end
    if (imem_req && prev_req && imem_addr != prev_addr) addr_changes++;
    if (instr_valid && prev_valid && !prev_xfer && instr != prev_instr) instr_changes++;
    prev_req   = imem_req;
    prev_addr  = imem_addr;
    prev_valid = instr_valid;
    prev_xfer  = instr_valid && instr_ready;
    prev_instr = instr;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input int delay, input logic ready);
    rst            = 1'b1;
    ack_delay      = delay;
    instr_ready    = ready;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    manual_en      = 1'b0;
    man_ack        = 1'b0;
    man_rdata      = '0;
    repeat (2) step();
    req_log.delete();
    xfer_pc.delete();
    xfer_instr.delete();
    xfer_cyc.delete();
    addr_changes  = 0;
    instr_changes = 0;
  endtask

  task automatic release_reset();
    rst      = 1'b0;
    rel_base = cyc;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = NOP;
  endtask

  task automatic run_until_halted(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!instr_valid && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    int  n;
    logic saw14;
    rst2 = 1'b1;

    // Test 1: zero-wait stream lw, sw, halt
    fill_mem();
    mem[0] = LW; mem[1] = SW; mem[2] = HLT;
    apply_stimulus(0, 1'b1);
    check_output("rst_req", imem_req, 0);
    check_output("rst_valid", instr_valid, 0);
    check_output("rst_halted", halted, 0);
    check_output("rst_instr", instr, 0);
    check_output("rst_instr_pc", instr_pc, 0);
    check_output("rst_addr", imem_addr, 0);
    check_output("rst2_addr", addr2, 32'hFFFF_FFFC);
    check_output("rst2_req", req2, 0);
    release_reset();
    run_until_halted(40);
    check_output("t1_halted", halted, 1);
    check_output("t1_xfers", xfer_pc.size(), 3);
    check_output("t1_pc0", xfer_pc[0], 32'h0);
    check_output("t1_pc1", xfer_pc[1], 32'h4);
    check_output("t1_pc2", xfer_pc[2], 32'h8);
    check_output("t1_instr2", xfer_instr[2], HLT);
    check_output("t1_cyc0", xfer_cyc[0], 2);
    check_output("t1_cyc1", xfer_cyc[1], 4);
    check_output("t1_cyc2", xfer_cyc[2], 6);
    check_output("t1_reqs", req_log.size(), 3);
    check_output("t1_req2", req_log[2], 32'h8);
    repeat (5) step();
    check_output("t1_req_after_halt", imem_req, 0);
    check_output("t1_valid_after_halt", instr_valid, 0);
    check_output("t1_reqs_after_halt", req_log.size(), 3);

    // Test 2: 3 wait cycles on imem, decode stalls 4 cycles
    fill_mem();
    mem[0] = LW; mem[1] = HLT;
    apply_stimulus(3, 1'b0);
    release_reset();
    wait_valid(20, n);
    check_output("t2_latency", n, 5);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("t2_hold_instr%0d", i), instr, LW);
      check_output($sformatf("t2_hold_valid%0d", i), instr_valid, 1);
      step();
    end
    instr_ready = 1'b1;
    run_until_halted(60);
    check_output("t2_halted", halted, 1);
    check_output("t2_xfers", xfer_pc.size(), 2);
    check_output("t2_pc1", xfer_pc[1], 32'h4);
    check_output("t2_addr_changes", addr_changes, 0);
    check_output("t2_instr_changes", instr_changes, 0);

    // Test 3: j at 0x10 targeting 0x100
    fill_mem();
    mem[4] = JMP; mem[5] = LW; mem[64] = HLT;
    apply_stimulus(0, 1'b1);
    release_reset();
    run_until_halted(60);
    check_output("t3_halted", halted, 1);
    check_output("t3_reqs", req_log.size(), 6);
    check_output("t3_req_j", req_log[4], 32'h10);
    check_output("t3_req_target", req_log[5], 32'h100);
    check_output("t3_xfer_target", xfer_pc[5], 32'h100);
    saw14 = 1'b0;
    foreach (req_log[i]) if (req_log[i] == 32'h14) saw14 = 1'b1;
    check_output("t3_no_fetch_14", saw14, 0);

    // Test 4: redirect while waiting on 0x8, stale ack must be discarded
    fill_mem();
    mem[2] = LW; mem[128] = HLT;
    apply_stimulus(3, 1'b1);
    release_reset();
    n = 0;
    while (!(imem_req && imem_addr == 32'h8) && n < 60) begin
      step();
      n++;
    end
    check_output("t4_reach_8", imem_addr, 32'h8);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    check_output("t4_redir_req", imem_req, 1);
    check_output("t4_redir_addr", imem_addr, 32'h200);
    run_until_halted(80);
    check_output("t4_halted", halted, 1);
    check_output("t4_xfers", xfer_pc.size(), 3);
    check_output("t4_xfer_pc", xfer_pc[2], 32'h200);
    check_output("t4_xfer_instr", xfer_instr[2], HLT);
    check_output("t4_reqs", req_log.size(), 4);

    // Test 5: redirect in HOLD with instr_ready=1, including a held halt
    fill_mem();
    mem[16] = HLT; mem[32] = NOP; mem[33] = HLT;
    apply_stimulus(0, 1'b0);
    release_reset();
    wait_valid(20, n);
    check_output("t5_first_pc", instr_pc, 32'h0);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    check_output("t5_dropped_valid", instr_valid, 0);
    check_output("t5_dropped_xfers", xfer_pc.size(), 0);
    check_output("t5_aligned_addr", imem_addr, 32'h40);
    wait_valid(20, n);
    check_output("t5_held_pc", instr_pc, 32'h40);
    check_output("t5_held_opcode", opcode, 32'h3F);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    check_output("t5_halt_squashed", halted, 0);
    check_output("t5_halt_valid", instr_valid, 0);
    check_output("t5_halt_addr", imem_addr, 32'h80);
    run_until_halted(40);
    check_output("t5_halted", halted, 1);
    check_output("t5_xfers", xfer_pc.size(), 2);
    check_output("t5_xfer0", xfer_pc[0], 32'h80);
    check_output("t5_xfer1", xfer_pc[1], 32'h84);

    // Test 6: reset pulse mid-wait with a stale ack, then the wrapping RESET_PC instance
    fill_mem();
    mem[1] = HLT;
    mem[0] = NOP;
    apply_stimulus(3, 1'b1);
    release_reset();
    repeat (2) step();
    manual_en = 1'b1;
    man_ack   = 1'b0;
    man_rdata = HLT;
    rst       = 1'b1;
    step();
    check_output("t6_rst_req", imem_req, 0);
    release_reset();
    man_ack = 1'b1;
    step();
    man_ack   = 1'b0;
    manual_en = 1'b0;
    check_output("t6_stale_valid", instr_valid, 0);
    check_output("t6_refetch_req", imem_req, 1);
    check_output("t6_refetch_addr", imem_addr, 32'h0);
    wait_valid(20, n);
    check_output("t6_first_pc", instr_pc, 32'h0);
    check_output("t6_first_instr", instr, NOP);
    run_until_halted(40);
    check_output("t6_halted", halted, 1);

    rst2 = 1'b0;
    step();
    check_output("t6_wrap_req", req2, 1);
    check_output("t6_wrap_first", addr2, 32'hFFFF_FFFC);
    step();
    check_output("t6_wrap_valid", valid2, 1);
    check_output("t6_wrap_instr_pc", instr_pc2, 32'hFFFF_FFFC);
    step();
    check_output("t6_wrap_next", addr2, 32'h0);
    check_output("t6_wrap_next_req", req2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
